// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver feeding a small first-word-fall-through byte FIFO.
//   It is the host->FPGA half of the debug serial link. The receiver samples
//   each bit in the middle of the bit. Consumers drain bytes with a valid/ready
//   handshake.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (27 MHz / 115200 = 234)
//   FIFO_DEPTH   : FIFO entries, power of 2, >= 2
//
// Ports
//   clk       in   system clock, the only clock
//   reset     in   synchronous, active-high reset
//   uart_rx   in   asynchronous serial input, idle high
//   rx_data   out  FIFO head byte, meaningful only while rx_valid=1
//   rx_valid  out  FIFO non-empty
//   rx_ready  in   consumer accepts rx_data this cycle
//   frame_err out  1-cycle pulse: stop bit low, byte discarded
//   overrun   out  1-cycle pulse: good byte arrived with FIFO full, byte dropped
//   busy      out  receiver FSM not idle
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Input synchroniser
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // Receiver state
  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_frame_err;
  logic            r_overrun;

  // FIFO state
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_pop;
  logic            w_push_ok;
  logic            w_push;
  logic            w_ferr;
  logic            w_ovr;
  logic            w_bit_end;

  assign rx_valid  = (r_count != '0);
  assign rx_data   = r_mem[r_rd_ptr];
  assign w_pop     = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign w_push_ok = (r_count < C_FULL) || w_pop;
  assign w_bit_end = (r_timer == T_LAST);

  // Next-state and event decode
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    w_ovr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_timer == T_HALF) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_idx == 3'd7)) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (w_rx_s) begin
            w_state_nxt = S_IDLE;
            if (w_push_ok) w_push = 1'b1;
            else           w_ovr  = 1'b1;
          end else begin
            w_state_nxt = S_BREAK;
            w_ferr      = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, bit timer, bit index, shift register, error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_err <= w_ferr;
      r_overrun   <= w_ovr;

      // Timer restarts on every state entry and wraps once per bit time.
      if ((w_state_nxt != r_state) || w_bit_end) r_timer <= '0;
      else                                       r_timer <= r_timer + TW'(1);

      if (r_state == S_START) begin
        r_idx <= '0;
      end else if ((r_state == S_DATA) && w_bit_end) begin
        r_shift[r_idx] <= w_rx_s;
        r_idx          <= r_idx + 3'd1;
      end
    end
  end

  // FIFO storage, not reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule
